serial_adder_multibit: RTL and testbench

Bit-serial multi-bit adder: captures two WIDTH-bit operands and a carry-in on a start strobe, then adds them LSB-first over WIDTH clock cycles using a single 1-bit full-adder cell with a registered carry. It sits directly upstream of the `full_adder_multibit_concat` cell and is its driver: it feeds the cell one bit-slice per cycle and consumes its 2-bit `{carry, sum}` result. It is the area-minimal adder datapath option for the arithmetic blocks.

---
 rtl/adder_pkg.sv | 25 ++
 rtl/full_adder_multibit_concat.sv | 14 +
 rtl/serial_adder_multibit.sv | 149 ++++++++++++++
 tb/tb_serial_adder_multibit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder datapath: FSM state
// encoding, the legal WIDTH range and the bit-counter sizing helper.
package adder_pkg;

  // Legal operand widths for the serial adder.
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Controller states. The encoding is fixed so that downstream debug
  // tooling can decode the state register directly.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width: enough bits to count 0..width-1. The counter
  // must be at least one bit wide, even for the smallest legal width.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : adder_pkg

// File: rtl/full_adder_multibit_concat.sv
// One-bit full-adder cell. It returns carry and sum packed together as
// a 2-bit word {carry, sum}, which is simply the arithmetic sum of the
// three input bits.
module full_adder_multibit_concat (
  input  logic       A_i,
  input  logic       B_i,
  input  logic       C_i,
  output logic [1:0] F_o
);

  // Zero-extend every input to two bits so the add produces the carry.
  assign F_o = {1'b0, A_i} + {1'b0, B_i} + {1'b0, C_i};

endmodule : full_adder_multibit_concat

// File: rtl/serial_adder_multibit.sv
// Bit-serial WIDTH-bit adder. The start strobe captures both operands
// and a carry-in. The adder then processes one bit per clock, LSB
// first, through a single full-adder cell with a registered carry. The
// result is published in S_o/C_o as the controller enters DONE, and
// done_o pulses for that one cycle.
module serial_adder_multibit
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             C_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] S_o,
  output logic             C_o
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Reject out-of-range widths at elaboration, not in silicon.
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_adder_multibit: WIDTH must lie between 2 and 32");
  end

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;      // operand A, consumed from bit 0
  logic [WIDTH-1:0] b_sh;      // operand B, consumed from bit 0
  logic [WIDTH-1:0] s_sh;      // sum bits, entering at the MSB
  logic [WIDTH-1:0] s_next;    // s_sh after the current bit step
  logic             carry;     // carry between bit steps
  logic [CNT_W-1:0] cnt;       // index of the bit being added

  logic [1:0]       cell_f;
  logic             cell_sum;
  logic             cell_carry;

  logic             load;      // accept a new operand set this edge
  logic             step;      // perform one bit step this edge
  logic             last;      // current step is the MSB

  // Single bit-slice cell fed from the low end of the operand shifters.
  full_adder_multibit_concat u_cell (
    .A_i (a_sh[0]),
    .B_i (b_sh[0]),
    .C_i (carry),
    .F_o (cell_f)
  );

  assign cell_carry = cell_f[1];
  assign cell_sum   = cell_f[0];

  // After WIDTH steps the first sum bit has travelled down to bit 0.
  // s_next then holds the complete sum word.
  assign s_next = {cell_sum, s_sh[WIDTH-1:1]};
  assign last   = (cnt == CNT_LAST);

  // State register with synchronous reset.
  // NOTE: clocked state is always written with <= so that every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the status outputs decoded from the state.
  // NOTE: each signal gets a default before the case. Any path that
  // leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_next = state;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy_o = 1'b1;
        step   = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy_o     = 1'b1;
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand shifters, sum shifter, carry and bit counter. A start
  // strobe seen outside IDLE never reaches this block, because load is
  // only raised in IDLE.
  // NOTE: the shifters are small flop arrays and not RAM. They are
  // reset so that an aborted addition leaves no stale partial state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      a_sh  <= A_i;
      b_sh  <= B_i;
      s_sh  <= '0;
      carry <= C_i;
      cnt   <= '0;
    end else if (step) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= s_next;
      carry <= cell_carry;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // Result registers. They update only on the final bit step and
  // otherwise hold the last completed result until the next one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      S_o <= '0;
      C_o <= 1'b0;
    end else if (step && last) begin
      S_o <= s_next;
      C_o <= cell_carry;
    end
  end

endmodule : serial_adder_multibit

// File: tb/tb_serial_adder_multibit.sv
// Directed bench for serial_adder_multibit at WIDTH=8, followed by a
// back-to-back sweep with random operands.
module tb_serial_adder_multibit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] s_out;
  logic         c_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] prev_s = '0;
  logic         prev_c = 1'b0;

  serial_adder_multibit #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .A_i     (a_in),
    .B_i     (b_in),
    .C_i     (cin),
    .busy_o  (busy),
    .done_o  (done),
    .S_o     (s_out),
    .C_o     (c_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Tick until done_o rises. Return the number of ticks, or -1 if it
  // never rises within the bound.
  task automatic wait_done(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  // Run one complete addition, starting in IDLE. Return the cycle in
  // which done_o was seen. The task ends in the following IDLE cycle.
  task automatic add_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c,
                        output int done_cyc);
    logic [W:0] want;
    int         k;
    want  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    cin   = ~c;
    check({tag, ":busy_at_start"}, 32'(busy), 32'd1);
    check({tag, ":s_hold"}, 32'(s_out), 32'(prev_s));
    check({tag, ":c_hold"}, 32'(c_out), 32'(prev_c));
    wait_done(k);
    done_cyc = cyc;
    check({tag, ":latency"}, 32'(k), 32'(W));
    check({tag, ":sum"}, 32'(s_out), 32'(want[W-1:0]));
    check({tag, ":carry"}, 32'(c_out), 32'(want[W]));
    tick();
    check({tag, ":done_one_cycle"}, 32'(done), 32'd0);
    check({tag, ":idle_after"}, 32'(busy), 32'd0);
    prev_s = want[W-1:0];
    prev_c = want[W];
  endtask

  initial begin
    int k;
    int dc;
    int last_dc;
    int pulses;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    // Reset, with a start strobe that must be ignored.
    rst   = 1'b1;
    start = 1'b1;
    a_in  = 8'hFF;
    b_in  = 8'hFF;
    cin   = 1'b1;
    tick();
    tick();
    check("rst:s", 32'(s_out), 32'h00);
    check("rst:c", 32'(c_out), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("rst:no_activity", 32'(busy), 32'd0);

    // Basic add, then full-width carry ripple cases.
    add_op("basic", 8'h12, 8'h34, 1'b0, dc);
    add_op("ripple_ff01", 8'hFF, 8'h01, 1'b0, dc);
    add_op("ripple_a55a", 8'hA5, 8'h5A, 1'b1, dc);

    // Start strobes during RUN and DONE are ignored.
    a_in  = 8'h12;
    b_in  = 8'h34;
    cin   = 1'b0;
    start = 1'b1;
    tick();                       // edge 0: accepted
    start = 1'b0;
    tick();
    tick();
    a_in  = 8'hFF;
    b_in  = 8'hFF;
    start = 1'b1;
    tick();                       // edge 3: ignored in RUN
    start = 1'b0;
    wait_done(k);
    check("ign:latency", 32'(k), 32'd5);
    check("ign:sum", 32'(s_out), 32'h46);
    check("ign:carry", 32'(c_out), 32'd0);
    start = 1'b1;
    tick();                       // edge 9: ignored in DONE
    check("ign:single_done", 32'(done), 32'd0);
    check("ign:idle", 32'(busy), 32'd0);
    check("ign:sum_hold", 32'(s_out), 32'h46);
    tick();                       // edge 10: accepted in IDLE
    start = 1'b0;
    check("ign:next_accepted", 32'(busy), 32'd1);
    wait_done(k);
    check("ign:next_latency", 32'(k), 32'(W));
    check("ign:next_sum", 32'(s_out), 32'hFE);
    check("ign:next_carry", 32'(c_out), 32'd1);
    tick();

    // Reset in the middle of a run aborts it and clears the result.
    a_in  = 8'hFF;
    b_in  = 8'hFF;
    cin   = 1'b0;
    start = 1'b1;
    tick();                       // edge 0
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();                       // edge 4: reset
    rst = 1'b0;
    check("abort:busy", 32'(busy), 32'd0);
    check("abort:done", 32'(done), 32'd0);
    check("abort:s", 32'(s_out), 32'h00);
    check("abort:c", 32'(c_out), 32'd0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check("abort:no_done", 32'(pulses), 32'd0);
    prev_s = '0;
    prev_c = 1'b0;

    // Back-to-back random sweep. Completions must be W+2 cycles apart.
    last_dc = 0;
    for (int n = 0; n < 200; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      add_op("sweep", ra, rb, rc, dc);
      if (n > 0) check("sweep:interval", 32'(dc - last_dc), 32'(W + 2));
      last_dc = dc;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_adder_multibit
